// File: rtl/mem_port_arb.sv
// Shared single-port SRAM arbiter for instruction fetch and load/store.
// Data has priority; a saturating counter lets a waiting fetch through.
module mem_port_arb #(
    parameter int STARVE_LIMIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    input  logic        data_req,
    input  logic [3:0]  data_wen,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        sram_en,
    output logic [3:0]  sram_wen,
    output logic [31:0] sram_addr,
    output logic [31:0] sram_wdata,
    input  logic [31:0] sram_rdata,
    output logic        inst_valid,
    output logic [31:0] inst_rdata,
    output logic        data_valid,
    output logic [31:0] data_rdata,
    output logic        stallreq
);

    localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_I,
        WAIT_D
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] starve_cnt;
    logic [CW-1:0] starve_nx;
    logic          store_q;
    logic          store_nx;
    logic          starved;

    assign starved = (starve_cnt == CW'(STARVE_LIMIT));

    // State, starvation counter and store flag of the outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            starve_cnt <= '0;
            store_q    <= 1'b0;
        end else begin
            state      <= state_nx;
            starve_cnt <= starve_nx;
            store_q    <= store_nx;
        end
    end

    // Arbitration, SRAM port drive, completion routing and stall request.
    always_comb begin
        state_nx   = state;
        starve_nx  = starve_cnt;
        store_nx   = store_q;
        sram_en    = 1'b0;
        sram_wen   = 4'b0;
        sram_addr  = 32'b0;
        sram_wdata = 32'b0;
        inst_valid = 1'b0;
        inst_rdata = 32'b0;
        data_valid = 1'b0;
        data_rdata = 32'b0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    if (inst_req && (!data_req || starved)) begin
                        sram_en   = 1'b1;
                        sram_addr = inst_addr;
                        state_nx  = WAIT_I;
                        starve_nx = '0;
                    end else if (data_req) begin
                        sram_en    = 1'b1;
                        sram_wen   = data_wen;
                        sram_addr  = data_addr;
                        sram_wdata = data_wdata;
                        state_nx   = WAIT_D;
                        store_nx   = |data_wen;
                        if (inst_req && !starved)
                            starve_nx = starve_cnt + CW'(1);
                    end
                end
                WAIT_I: begin
                    inst_valid = 1'b1;
                    inst_rdata = sram_rdata;
                    state_nx   = IDLE;
                end
                WAIT_D: begin
                    data_valid = 1'b1;
                    data_rdata = store_q ? 32'b0 : sram_rdata;
                    state_nx   = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
        stallreq = !rst && ((inst_req && !inst_valid) ||
                            (data_req && !data_valid));
    end

endmodule

// File: tb/tb_mem_port_arb.sv
// Directed per-cycle vector bench for mem_port_arb.
// Inputs change just after the rising edge; outputs are sampled at the falling edge.
module tb_mem_port_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        data_req;
    logic [3:0]  data_wen;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        sram_en;
    logic [3:0]  sram_wen;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;
    logic        inst_valid;
    logic [31:0] inst_rdata;
    logic        data_valid;
    logic [31:0] data_rdata;
    logic        stallreq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    mem_port_arb #(.STARVE_LIMIT(2)) dut (
        .clk(clk),
        .rst(rst),
        .inst_req(inst_req),
        .inst_addr(inst_addr),
        .data_req(data_req),
        .data_wen(data_wen),
        .data_addr(data_addr),
        .data_wdata(data_wdata),
        .sram_en(sram_en),
        .sram_wen(sram_wen),
        .sram_addr(sram_addr),
        .sram_wdata(sram_wdata),
        .sram_rdata(sram_rdata),
        .inst_valid(inst_valid),
        .inst_rdata(inst_rdata),
        .data_valid(data_valid),
        .data_rdata(data_rdata),
        .stallreq(stallreq)
    );

    typedef struct {
        string       tag;
        logic        rst;
        logic        ireq;
        logic [31:0] iaddr;
        logic        dreq;
        logic [3:0]  dwen;
        logic [31:0] daddr;
        logic [31:0] dwdata;
        logic [31:0] srd;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        iv;
        logic [31:0] ird;
        logic        dv;
        logic [31:0] drd;
        logic        stall;
    } vec_t;

    vec_t vq[$];

    task automatic add(
        input string tag,
        input logic r, input logic ir, input logic [31:0] ia,
        input logic dr, input logic [3:0] dw, input logic [31:0] da,
        input logic [31:0] dd, input logic [31:0] sr,
        input logic en, input logic [3:0] wen, input logic [31:0] ad,
        input logic [31:0] wd, input logic iv, input logic [31:0] ird,
        input logic dv, input logic [31:0] drd, input logic st);
        vec_t v;
        v.tag = tag; v.rst = r; v.ireq = ir; v.iaddr = ia;
        v.dreq = dr; v.dwen = dw; v.daddr = da; v.dwdata = dd;
        v.srd = sr; v.en = en; v.wen = wen; v.addr = ad;
        v.wdata = wd; v.iv = iv; v.ird = ird; v.dv = dv;
        v.drd = drd; v.stall = st;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        rst        = v.rst;
        inst_req   = v.ireq;
        inst_addr  = v.iaddr;
        data_req   = v.dreq;
        data_wen   = v.dwen;
        data_addr  = v.daddr;
        data_wdata = v.dwdata;
        sram_rdata = v.srd;
    endtask

    task automatic check_vec(input vec_t v);
        chk({v.tag, ".sram_en"},    {31'b0, sram_en},    {31'b0, v.en});
        chk({v.tag, ".sram_wen"},   {28'b0, sram_wen},   {28'b0, v.wen});
        chk({v.tag, ".sram_addr"},  sram_addr,           v.addr);
        chk({v.tag, ".sram_wdata"}, sram_wdata,          v.wdata);
        chk({v.tag, ".inst_valid"}, {31'b0, inst_valid}, {31'b0, v.iv});
        chk({v.tag, ".inst_rdata"}, inst_rdata,          v.ird);
        chk({v.tag, ".data_valid"}, {31'b0, data_valid}, {31'b0, v.dv});
        chk({v.tag, ".data_rdata"}, data_rdata,          v.drd);
        chk({v.tag, ".stallreq"},   {31'b0, stallreq},   {31'b0, v.stall});
    endtask

    task automatic run_vec(input vec_t v);
        drive(v);
        @(negedge clk);
        check_vec(v);
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] IA = 32'h0000_3000;
    localparam logic [31:0] DA = 32'h0000_0100;

    initial begin
        vec_t v;

        // reset state
        add("rst0", 1, 0, 0, 0, 0, 0, 0, 32'h1111_1111,
            0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rst1", 1, 0, 0, 0, 0, 0, 0, 32'h1111_1111,
            0, 0, 0, 0, 0, 0, 0, 0, 0);
        // single fetch
        add("fetch_iss", 0, 1, 32'h1000, 0, 0, 0, 0, 32'h1111_1111,
            1, 0, 32'h1000, 0, 0, 0, 0, 0, 1);
        add("fetch_cmp", 0, 1, 32'h1000, 0, 0, 0, 0, 32'h2402_0005,
            0, 0, 0, 0, 1, 32'h2402_0005, 0, 0, 0);
        add("idle_a", 0, 0, 0, 0, 0, 0, 0, 32'h3333_3333,
            0, 0, 0, 0, 0, 0, 0, 0, 0);
        // simultaneous: data first, then inst
        add("sim_d_iss", 0, 1, 32'h2000, 1, 0, 32'h80, 32'h5A5A, 32'h0,
            1, 0, 32'h80, 32'h5A5A, 0, 0, 0, 0, 1);
        add("sim_d_cmp", 0, 1, 32'h2000, 1, 0, 32'h80, 32'h5A5A, 32'hCAFE_0001,
            0, 0, 0, 0, 0, 0, 1, 32'hCAFE_0001, 1);
        add("sim_i_iss", 0, 1, 32'h2000, 0, 0, 0, 0, 32'h0,
            1, 0, 32'h2000, 0, 0, 0, 0, 0, 1);
        add("sim_i_cmp", 0, 1, 32'h2000, 0, 0, 0, 0, 32'h1234_5678,
            0, 0, 0, 0, 1, 32'h1234_5678, 0, 0, 0);
        add("idle_b", 0, 0, 0, 0, 0, 0, 0, 32'h0,
            0, 0, 0, 0, 0, 0, 0, 0, 0);
        // starvation: D D I D D I with both held high
        for (int k = 0; k < 6; k++) begin
            logic is_i;
            logic [31:0] rd;
            is_i = (k % 3 == 2);
            rd = 32'hA000_0000 + 32'(k);
            if (is_i) begin
                add($sformatf("starve%0d_i_iss", k), 0, 1, IA, 1, 0, DA, 0, 0,
                    1, 0, IA, 0, 0, 0, 0, 0, 1);
                add($sformatf("starve%0d_i_cmp", k), 0, 1, IA, 1, 0, DA, 0, rd,
                    0, 0, 0, 0, 1, rd, 0, 0, 1);
            end else begin
                add($sformatf("starve%0d_d_iss", k), 0, 1, IA, 1, 0, DA, 0, 0,
                    1, 0, DA, 0, 0, 0, 0, 0, 1);
                add($sformatf("starve%0d_d_cmp", k), 0, 1, IA, 1, 0, DA, 0, rd,
                    0, 0, 0, 0, 0, 0, 1, rd, 1);
            end
        end
        add("idle_c", 0, 0, 0, 0, 0, 0, 0, 32'h0,
            0, 0, 0, 0, 0, 0, 0, 0, 0);
        // store
        add("st_iss", 0, 0, 0, 1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 32'h0,
            1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 0, 0, 0, 0, 1);
        add("st_cmp", 0, 0, 0, 1, 4'b0011, 32'h40, 32'hDEAD_BEEF, 32'h5555_5555,
            0, 0, 0, 0, 0, 0, 1, 0, 0);
        // fetch that drops its request while outstanding still completes
        add("drop_iss", 0, 1, 32'h500, 0, 0, 0, 0, 32'h0,
            1, 0, 32'h500, 0, 0, 0, 0, 0, 1);
        add("drop_cmp", 0, 0, 0, 0, 0, 0, 0, 32'h77,
            0, 0, 0, 0, 1, 32'h77, 0, 0, 0);

        foreach (vq[i]) run_vec(vq[i]);

        // reset while a load is outstanding: discarded, then reissued
        vq.delete();
        add("rmid_iss", 0, 0, 0, 1, 0, 32'h84, 0, 32'h0,
            1, 0, 32'h84, 0, 0, 0, 0, 0, 1);
        add("rmid_rst", 1, 0, 0, 1, 0, 32'h84, 0, 32'hBAD0_BAD0,
            0, 0, 0, 0, 0, 0, 0, 0, 0);
        add("rmid_reiss", 0, 0, 0, 1, 0, 32'h84, 0, 32'h0,
            1, 0, 32'h84, 0, 0, 0, 0, 0, 1);
        add("rmid_cmp", 0, 0, 0, 1, 0, 32'h84, 0, 32'h99,
            0, 0, 0, 0, 0, 0, 1, 32'h99, 0);
        foreach (vq[i]) run_vec(vq[i]);

        // ten idle cycles
        v = '{tag: "idle10", rst: 0, ireq: 0, iaddr: 0, dreq: 0, dwen: 0,
              daddr: 0, dwdata: 0, srd: 0, en: 0, wen: 0, addr: 0,
              wdata: 0, iv: 0, ird: 0, dv: 0, drd: 0, stall: 0};
        for (int c = 0; c < 10; c++) begin
            v.srd = 32'hF0F0_0000 + 32'(c);
            run_vec(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_port_arb.md
MEM_PORT_ARB -- requirements
Module: mem_port_arb

Interface
REQ-001 Parameter: STARVE_LIMIT, default 2, number of consecutive data grants allowed while an instruction request waits.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 inst_req  input  1  fetch request, level, held until inst_valid.
REQ-005 inst_addr  input  32  fetch address, stable while inst_req is high.
REQ-006 data_req  input  1  load/store request, level, held until data_valid.
REQ-007 data_wen  input  4  byte write enables; 0 means load.
REQ-008 data_addr  input  32  data address, stable while data_req is high.
REQ-009 data_wdata  input  32  store data.
REQ-010 sram_en  output  1  shared SRAM port enable.
REQ-011 sram_wen  output  4  shared SRAM byte write enables.
REQ-012 sram_addr  output  32  shared SRAM address.
REQ-013 sram_wdata  output  32  shared SRAM write data.
REQ-014 sram_rdata  input  32  SRAM read data, valid exactly 1 cycle after an enabled access.
REQ-015 inst_valid  output  1  one-cycle pulse; fetch complete.
REQ-016 inst_rdata  output  32  fetched word, qualified by inst_valid.
REQ-017 data_valid  output  1  one-cycle pulse; load/store complete.
REQ-018 data_rdata  output  32  load word, qualified by data_valid.
REQ-019 stallreq  output  1  pipeline stall request to the stall controller.

Function
REQ-020 FSM states: IDLE, WAIT_I, WAIT_D.
REQ-021 In IDLE with any request, the winner is driven onto the SRAM port combinationally in the same cycle, and the FSM moves to WAIT_I or WAIT_D.
REQ-022 In WAIT_x, sram_rdata is captured and routed to x_rdata, x_valid pulses for exactly that cycle, the SRAM port is idle, and the FSM returns to IDLE.
REQ-023 Each access takes 2 cycles (issue plus complete), so throughput is at most one access per 2 cycles.
REQ-024 Priority: data wins over inst.
REQ-025 Exception to priority: if starve_cnt equals STARVE_LIMIT and both requests are present, inst wins.
REQ-026 starve_cnt behaviour: it increments on each data grant issued while inst_req is high, saturating at STARVE_LIMIT, and it clears on every inst grant.
REQ-027 Losing-requester port values are never driven; when the port is idle, sram_en = 0, sram_wen = 0, and sram_addr and sram_wdata = 0.
REQ-028 An inst grant forces sram_wen = 0; a data grant passes data_wen and data_wdata through.
REQ-029 Stores (data_wen != 0) complete with data_valid = 1 and data_rdata = 0.
REQ-030 inst_rdata and data_rdata are 0 whenever their valid is 0.
REQ-031 stallreq = (inst_req & ~inst_valid) | (data_req & ~data_valid), computed combinationally.
REQ-032 A request dropped before its grant is ignored.
REQ-033 A request already issued always completes with a valid pulse, even if the request drops during WAIT_x.
REQ-034 Back-to-back: a requester held high after its valid is re-arbitrated in the following IDLE cycle.

Reset
REQ-035 On rst: state = IDLE, starve_cnt = 0, all outputs 0 in the cycle after the reset edge; valid pulses are not asserted while rst is high.
REQ-036 rst during WAIT_x discards the outstanding access: no valid pulse, and the requester re-arbitrates after reset.

Verification
REQ-037 Single fetch: inst_req = 1, addr 0x0000_1000; SRAM returns 0x2402_0005 -> sram_en = 1 in cycle 0; inst_valid = 1, inst_rdata = 0x2402_0005 in cycle 1; stallreq = 1 in cycle 0, 0 in cycle 1.
REQ-038 Simultaneous requests: data load to 0x80 plus fetch -> data granted first (cycles 0-1), inst granted in cycles 2-3.
REQ-039 Starvation, STARVE_LIMIT = 2: data_req and inst_req held high continuously -> grant order D, D, I, D, D, I.
REQ-040 Store: data_wen = 4'b0011, addr 0x40, wdata 0xDEAD_BEEF -> sram_wen = 0011, sram_wdata = 0xDEAD_BEEF in the issue cycle; next cycle data_valid = 1, data_rdata = 0.
REQ-041 Reset mid-access: rst asserted in WAIT_D -> no data_valid; after rst drops with data_req high, the access reissues, then data_valid pulses 1 cycle later.
REQ-042 Idle check: no requests for 10 cycles -> sram_en = 0, stallreq = 0, and both valids 0 throughout.
